// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// mux select codes, error codes and the control-word bundle.
package multicycle_control_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB  = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR  = 4'd5;
  localparam logic [STATE_W-1:0] S_EXECR  = 4'd6;
  localparam logic [STATE_W-1:0] S_ALUWB  = 4'd7;
  localparam logic [STATE_W-1:0] S_BEQ    = 4'd8;
  localparam logic [STATE_W-1:0] S_HALT   = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       halt;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles spent waiting on the memory port and flags a timeout on the
// last allowed waiting cycle unless ready arrives in that same cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  input  logic ready,
  output logic timeout_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // MEM_TIMEOUT of zero disables the compare entirely
  assign timeout_c = (MEM_TIMEOUT != 0) && waiting && !ready && (count == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || ready) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/
// execute/memory/writeback over one shared memory port with a ready handshake.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [6:0]   opcode_in,
  input  logic         zero_in,
  input  logic         mem_ready_in,
  output logic [1:0]   ALUOp_out,
  output logic [1:0]   alu_src_a_out,
  output logic [1:0]   alu_src_b_out,
  output logic [1:0]   result_src_out,
  output logic         adr_src_out,
  output logic         mem_read_out,
  output logic         mem_write_out,
  output logic         ir_write_out,
  output logic         pc_write_out,
  output logic         reg_write_out,
  output logic         halt_out,
  output logic [1:0]   err_code_out,
  output logic [3:0]   state_out
);

  logic [STATE_W-1:0] state, state_nxt;
  logic [1:0]         err_code, err_nxt;
  logic               waiting;
  logic               timeout_c;
  ctrl_t              ctrl;

  assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_nxt != state),
    .waiting  (waiting),
    .ready    (mem_ready_in),
    .timeout_c(timeout_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      err_code <= err_nxt;
    end
  end

  // Next-state and error capture
  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    case (state)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready_in) begin
          state_nxt = (state == S_FETCH) ? S_DECODE :
                      (state == S_MEMRD) ? S_MEMWB  : S_FETCH;
        end else if (timeout_c) begin
          state_nxt = S_HALT;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode_in)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_BRANCH:         state_nxt = S_BEQ;
          default: begin
            state_nxt = S_HALT;
            err_nxt   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_nxt = (opcode_in == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMWB, S_ALUWB, S_BEQ: state_nxt = S_FETCH;
      S_EXECR:  state_nxt = S_ALUWB;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_HALT;
    endcase
  end

  // Moore decode by state; ir/pc write gated by ready/zero; all quiet in reset
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.adr_src    = ADR_PC;
        ctrl.src_a      = SRC_A_PC;
        ctrl.src_b      = SRC_B_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready_in;
        ctrl.pc_write   = mem_ready_in;
      end
      S_DECODE: begin
        ctrl.src_a  = SRC_A_OLDPC;
        ctrl.src_b  = SRC_B_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.src_a  = SRC_A_REG;
        ctrl.src_b  = SRC_B_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read   = 1'b1;
        ctrl.adr_src    = ADR_RESULT;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = ADR_RESULT;
        ctrl.result_src = RES_ALUOUT;
      end
      S_EXECR: begin
        ctrl.src_a  = SRC_A_REG;
        ctrl.src_b  = SRC_B_REG;
        ctrl.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.src_a      = SRC_A_REG;
        ctrl.src_b      = SRC_B_REG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero_in;
      end
      S_HALT:  ctrl.halt = 1'b1;
      default: ctrl = '0;
    endcase
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  assign ALUOp_out      = ctrl.alu_op;
  assign alu_src_a_out  = ctrl.src_a;
  assign alu_src_b_out  = ctrl.src_b;
  assign result_src_out = ctrl.result_src;
  assign adr_src_out    = ctrl.adr_src;
  assign mem_read_out   = ctrl.mem_read;
  assign mem_write_out  = ctrl.mem_write;
  assign ir_write_out   = ctrl.ir_write;
  assign pc_write_out   = ctrl.pc_write;
  assign reg_write_out  = ctrl.reg_write;
  assign halt_out       = ctrl.halt;
  assign err_code_out   = err_code;
  assign state_out      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction flows, branch gating,
// memory timeout, ready/timeout race, illegal opcode and async reset.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode_in;
  logic       zero_in;
  logic       mem_ready_in;
  logic [1:0] ALUOp_out, alu_src_a_out, alu_src_b_out, result_src_out;
  logic       adr_src_out, mem_read_out, mem_write_out;
  logic       ir_write_out, pc_write_out, reg_write_out, halt_out;
  logic [1:0] err_code_out;
  logic [3:0] state_out;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode_in     (opcode_in),
    .zero_in       (zero_in),
    .mem_ready_in  (mem_ready_in),
    .ALUOp_out     (ALUOp_out),
    .alu_src_a_out (alu_src_a_out),
    .alu_src_b_out (alu_src_b_out),
    .result_src_out(result_src_out),
    .adr_src_out   (adr_src_out),
    .mem_read_out  (mem_read_out),
    .mem_write_out (mem_write_out),
    .ir_write_out  (ir_write_out),
    .pc_write_out  (pc_write_out),
    .reg_write_out (reg_write_out),
    .halt_out      (halt_out),
    .err_code_out  (err_code_out),
    .state_out     (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ends on a falling edge with reset released and the FSM in FETCH
  task do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_reset();
    mem_ready_in = 1'b1;
    #1;
    total++; if (state_out !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_out); end
    total++; if (mem_read_out !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%b exp=0", mem_read_out); end
    total++; if (ir_write_out !== 1'b0 || pc_write_out !== 1'b0) begin bad++; $display("FAIL rst_enables got=%b%b exp=00", ir_write_out, pc_write_out); end
    total++; if (alu_src_b_out !== 2'b00 || result_src_out !== 2'b00) begin bad++; $display("FAIL rst_selects got=%b/%b exp=00/00", alu_src_b_out, result_src_out); end
    total++; if (err_code_out !== 2'b00 || halt_out !== 1'b0) begin bad++; $display("FAIL rst_err got=%b/%b exp=00/0", err_code_out, halt_out); end
    mem_ready_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (mem_read_out !== 1'b1 || alu_src_b_out !== 2'b10 || result_src_out !== 2'b10) begin bad++; $display("FAIL fetch_decode got=%b/%b/%b exp=1/10/10", mem_read_out, alu_src_b_out, result_src_out); end
  endtask

  task test_lw();
    logic [3:0] es [10];
    logic       rd [10];
    logic       rw [10];
    logic       iw [10];
    es = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    rd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    iw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode_in = 7'b0000011;
    zero_in = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mem_ready_in = rd[i];
      #1;
      total++; if (state_out !== es[i]) begin bad++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, state_out, es[i]); end
      total++; if (ALUOp_out !== 2'b00) begin bad++; $display("FAIL lw_aluop cyc=%0d got=%b exp=00", i, ALUOp_out); end
      total++; if (reg_write_out !== rw[i]) begin bad++; $display("FAIL lw_reg_write cyc=%0d got=%b exp=%b", i, reg_write_out, rw[i]); end
      total++; if (ir_write_out !== iw[i]) begin bad++; $display("FAIL lw_ir_write cyc=%0d got=%b exp=%b", i, ir_write_out, iw[i]); end
      if (es[i] == 4'd3) begin
        total++; if (mem_read_out !== 1'b1 || adr_src_out !== 1'b1) begin bad++; $display("FAIL lw_memrd cyc=%0d got=%b/%b exp=1/1", i, mem_read_out, adr_src_out); end
      end
      @(negedge clk);
    end
  endtask

  task test_rtype();
    logic [3:0] es [5];
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode_in = 7'b0110011;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready_in = 1'b1;
      #1;
      total++; if (state_out !== es[i]) begin bad++; $display("FAIL rtype_state cyc=%0d got=%0d exp=%0d", i, state_out, es[i]); end
      if (i == 1) begin
        total++; if (alu_src_a_out !== 2'b01 || alu_src_b_out !== 2'b01) begin bad++; $display("FAIL decode_srcs got=%b/%b exp=01/01", alu_src_a_out, alu_src_b_out); end
      end
      if (i == 2) begin
        total++; if (ALUOp_out !== 2'b10 || alu_src_a_out !== 2'b10 || alu_src_b_out !== 2'b00) begin bad++; $display("FAIL execr_ctrl got=%b/%b/%b exp=10/10/00", ALUOp_out, alu_src_a_out, alu_src_b_out); end
      end
      if (i == 3) begin
        total++; if (reg_write_out !== 1'b1 || result_src_out !== 2'b00) begin bad++; $display("FAIL aluwb_ctrl got=%b/%b exp=1/00", reg_write_out, result_src_out); end
      end
      @(negedge clk);
    end
  endtask

  task test_beq(input logic z);
    opcode_in = 7'b1100011;
    zero_in = z;
    do_reset();
    mem_ready_in = 1'b1;
    #1;
    total++; if (pc_write_out !== 1'b1) begin bad++; $display("FAIL beq_fetch_pc got=%b exp=1", pc_write_out); end
    @(negedge clk);
    mem_ready_in = 1'b0;
    @(negedge clk);
    #1;
    total++; if (state_out !== 4'd8 || ALUOp_out !== 2'b01) begin bad++; $display("FAIL beq_state z=%b got=%0d/%b exp=8/01", z, state_out, ALUOp_out); end
    total++; if (pc_write_out !== z) begin bad++; $display("FAIL beq_pc_write z=%b got=%b exp=%b", z, pc_write_out, z); end
    @(negedge clk);
    #1;
    total++; if (state_out !== 4'd0) begin bad++; $display("FAIL beq_return z=%b got=%0d exp=0", z, state_out); end
  endtask

  task test_illegal();
    opcode_in = 7'b0010011;
    do_reset();
    mem_ready_in = 1'b1;
    @(negedge clk);
    mem_ready_in = 1'b0;
    @(negedge clk);
    #1;
    total++; if (state_out !== 4'd15 || halt_out !== 1'b1) begin bad++; $display("FAIL illegal_halt got=%0d/%b exp=15/1", state_out, halt_out); end
    total++; if (err_code_out !== 2'b01) begin bad++; $display("FAIL illegal_err got=%b exp=01", err_code_out); end
    total++; if (mem_read_out !== 1'b0) begin bad++; $display("FAIL illegal_strobe got=%b exp=0", mem_read_out); end
  endtask

  // Brings a store up to MEMWR with ready deasserted
  task goto_memwr();
    opcode_in = 7'b0100011;
    do_reset();
    mem_ready_in = 1'b1;
    @(negedge clk);
    mem_ready_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task test_sw_timeout();
    goto_memwr();
    #1;
    total++; if (err_code_out !== 2'b00) begin bad++; $display("FAIL sw_err_cleared got=%b exp=00", err_code_out); end
    for (int i = 0; i < 16; i++) begin
      total++; if (state_out !== 4'd5 || mem_write_out !== 1'b1) begin bad++; $display("FAIL sw_wait cyc=%0d got=%0d/%b exp=5/1", i, state_out, mem_write_out); end
      @(negedge clk);
      #1;
    end
    total++; if (state_out !== 4'd15 || halt_out !== 1'b1) begin bad++; $display("FAIL sw_halt got=%0d/%b exp=15/1", state_out, halt_out); end
    total++; if (err_code_out !== 2'b10) begin bad++; $display("FAIL sw_timeout_err got=%b exp=10", err_code_out); end
    total++; if (mem_write_out !== 1'b0 || mem_read_out !== 1'b0 || reg_write_out !== 1'b0) begin bad++; $display("FAIL sw_halt_strobes got=%b%b%b exp=000", mem_write_out, mem_read_out, reg_write_out); end
    mem_ready_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (state_out !== 4'd15 || err_code_out !== 2'b10 || ir_write_out !== 1'b0 || pc_write_out !== 1'b0) begin bad++; $display("FAIL halt_sticky got=%0d/%b/%b%b exp=15/10/00", state_out, err_code_out, ir_write_out, pc_write_out); end
  endtask

  task test_ready_race();
    goto_memwr();
    repeat (15) @(negedge clk);
    mem_ready_in = 1'b1;
    #1;
    total++; if (state_out !== 4'd5) begin bad++; $display("FAIL race_pre got=%0d exp=5", state_out); end
    @(negedge clk);
    mem_ready_in = 1'b0;
    #1;
    total++; if (state_out !== 4'd0 || halt_out !== 1'b0 || err_code_out !== 2'b00) begin bad++; $display("FAIL race_ready_wins got=%0d/%b/%b exp=0/0/00", state_out, halt_out, err_code_out); end
  endtask

  task test_async_reset();
    goto_memwr();
    @(negedge clk);
    #1;
    total++; if (mem_write_out !== 1'b1) begin bad++; $display("FAIL ar_pre_write got=%b exp=1", mem_write_out); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (mem_write_out !== 1'b0 || state_out !== 4'd0) begin bad++; $display("FAIL ar_drop got=%b/%0d exp=0/0", mem_write_out, state_out); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (state_out !== 4'd0 || err_code_out !== 2'b00 || mem_read_out !== 1'b1) begin bad++; $display("FAIL ar_release got=%0d/%b/%b exp=0/00/1", state_out, err_code_out, mem_read_out); end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode_in = 7'b0000011;
    zero_in = 1'b0;
    mem_ready_in = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal();
    test_sw_timeout();
    test_ready_race();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
